// File: rtl/wb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Constants and types shared between the register-file write-port arbiter and
// its result FIFO.
//   CPU_DATA_W   : register/data width
//   CPU_ADDR_W   : register address width
//   CPU_NUM_REGS : number of architectural registers
//   port_owner_e : which source drives the register-file write port this cycle
// -----------------------------------------------------------------------------
package wb_port_arbiter_pkg;

    localparam int CPU_DATA_W   = 16;
    localparam int CPU_ADDR_W   = 4;
    localparam int CPU_NUM_REGS = 1 << CPU_ADDR_W;

    typedef enum logic [1:0] {
        PORT_IDLE   = 2'd0,
        PORT_WSTAGE = 2'd1,
        PORT_MC     = 2'd2
    } port_owner_e;

endpackage

// File: rtl/wb_result_fifo.sv
// -----------------------------------------------------------------------------
// wb_result_fifo
// Small synchronous FIFO that buffers multicycle results until the register
// file write port is free.
//   clk, reset : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write pushData at the clock edge (ignored when full)
//   pushData   : entry to write
//   pop        : discard the head entry at the clock edge (ignored when empty)
//   full/empty : occupancy flags from registered state
//   count      : number of valid entries
//   headData   : oldest entry, valid whenever empty is 0
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module wb_result_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         headData
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = mem[rdPtr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Sole owner of the register-file write port. The in-order W stage always wins
// the port; buffered multicycle (mul/div) results use it on cycles where the W
// stage does not write. Also keeps a busy scoreboard of multicycle
// destinations and raises stall_req when a buffered result is starved.
//
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   RegWriteW, MemToRegW,
//   destAddW, MemReadDataW,
//   alu_resultW                : W-stage write request (combinational path)
//   mc_issue, mc_issue_dest    : multicycle op issued, marks dest busy
//   mc_valid, mc_ready,
//   mc_dest, mc_data           : multicycle result handshake
//   rf_we, rf_waddr, rf_wdata  : register-file write port
//   busy_mask                  : bit i set = reg i awaits multicycle writeback
//   stall_req                  : ask hazard unit for writeback bubbles
//   scoreboard_err             : sticky protocol-violation flag
//
// Handshake: a result transfers on a rising edge where mc_valid && mc_ready.
// mc_ready depends only on registered FIFO occupancy, never on mc_valid. While
// mc_valid is high and mc_ready low, the source must hold mc_dest/mc_data.
// -----------------------------------------------------------------------------
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = CPU_DATA_W,
    parameter int ADDR_W       = CPU_ADDR_W,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RegWriteW,
    input  logic                     MemToRegW,
    input  logic [ADDR_W-1:0]        destAddW,
    input  logic [DATA_W-1:0]        MemReadDataW,
    input  logic [DATA_W-1:0]        alu_resultW,
    input  logic                     mc_issue,
    input  logic [ADDR_W-1:0]        mc_issue_dest,
    input  logic                     mc_valid,
    output logic                     mc_ready,
    input  logic [ADDR_W-1:0]        mc_dest,
    input  logic [DATA_W-1:0]        mc_data,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [(1<<ADDR_W)-1:0]   busy_mask,
    output logic                     stall_req,
    output logic                     scoreboard_err
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int ENTRY_W  = ADDR_W + DATA_W;
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic                fifoFull;
    logic                fifoEmpty;
    logic [CNT_W-1:0]    fifoCount;
    logic [ENTRY_W-1:0]  headEntry;
    logic [ADDR_W-1:0]   headDest;
    logic [DATA_W-1:0]   headData;
    logic                mcPush;
    logic                mcPop;
    port_owner_e         owner;
    logic [STARVE_W-1:0] starveCnt;
    logic [NUM_REGS-1:0] busyNext;
    logic                issueClash;
    logic                popOrphan;

    assign mc_ready = !fifoFull;
    assign mcPush   = mc_valid && !fifoFull;
    // The head is granted only on cycles the W stage leaves the port free.
    assign mcPop    = !fifoEmpty && !RegWriteW;

    assign headDest = headEntry[ENTRY_W-1:DATA_W];
    assign headData = headEntry[DATA_W-1:0];

    wb_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (mcPush),
        .pushData ({mc_dest, mc_data}),
        .pop      (mcPop),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount),
        .headData (headEntry)
    );

    // Port ownership; reset gating keeps rf_we low while reset is held even
    // if the W stage is still presenting a write.
    always_comb begin
        owner = PORT_IDLE;
        if (!reset) begin
            owner = PORT_IDLE;
        end else if (RegWriteW) begin
            owner = PORT_WSTAGE;
        end else if (!fifoEmpty) begin
            owner = PORT_MC;
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (owner)
            PORT_WSTAGE: begin
                rf_we    = 1'b1;
                rf_waddr = destAddW;
                rf_wdata = MemToRegW ? MemReadDataW : alu_resultW;
            end
            PORT_MC: begin
                rf_we    = 1'b1;
                rf_waddr = headDest;
                rf_wdata = headData;
            end
            default: begin
                rf_we    = 1'b0;
            end
        endcase
    end

    // Starvation: a non-empty FIFO that is not popped is necessarily denied
    // by the W stage, so that is the only case the counter advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starveCnt <= '0;
        end else if (mcPop || (fifoCount == '0)) begin
            starveCnt <= '0;
        end else if (starveCnt != STARVE_W'(STARVE_LIMIT)) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

    // stall_req follows the saturated counter by one cycle and drops the
    // cycle after a pop; the pop also clears the counter so it cannot
    // re-assert until a fresh run of denials.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_req <= 1'b0;
        end else if (mcPop) begin
            stall_req <= 1'b0;
        end else if (starveCnt == STARVE_W'(STARVE_LIMIT)) begin
            stall_req <= 1'b1;
        end
    end

    // Busy scoreboard: clear on pop first, then set on issue so a same-cycle
    // set of the same register wins.
    always_comb begin
        busyNext = busy_mask;
        if (mcPop) begin
            busyNext[headDest] = 1'b0;
        end
        if (mc_issue) begin
            busyNext[mc_issue_dest] = 1'b1;
        end
    end

    // Re-issuing to a register that is being written back this very cycle is
    // legal: its previous result leaves the scoreboard at the same edge.
    assign issueClash = mc_issue && busy_mask[mc_issue_dest] &&
                        !(mcPop && (headDest == mc_issue_dest));
    assign popOrphan  = mcPop && !busy_mask[headDest];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_mask      <= '0;
            scoreboard_err <= 1'b0;
        end else begin
            busy_mask      <= busyNext;
            scoreboard_err <= scoreboard_err | issueClash | popOrphan;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Scoreboard bench for wb_port_arbiter. The driver applies one cycle of
// stimulus, asks a queue-based reference model for that cycle's expected
// outputs and pushes them to expected queues; a monitor on the falling edge
// pops and compares. Directed scenarios come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NR    = 1 << AW;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic          RegWriteW, MemToRegW;
    logic [AW-1:0] destAddW;
    logic [DW-1:0] MemReadDataW, alu_resultW;
    logic          mc_issue;
    logic [AW-1:0] mc_issue_dest;
    logic          mc_valid, mc_ready;
    logic [AW-1:0] mc_dest;
    logic [DW-1:0] mc_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [NR-1:0] busy_mask;
    logic          stall_req, scoreboard_err;

    wb_port_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .destAddW(destAddW),
        .MemReadDataW(MemReadDataW), .alu_resultW(alu_resultW),
        .mc_issue(mc_issue), .mc_issue_dest(mc_issue_dest),
        .mc_valid(mc_valid), .mc_ready(mc_ready),
        .mc_dest(mc_dest), .mc_data(mc_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_mask(busy_mask), .stall_req(stall_req),
        .scoreboard_err(scoreboard_err)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    // status entry: {we, ready, stall, err, busy[15:0]}
    logic [19:0]      exp_st_q[$];
    logic [AW+DW-1:0] exp_wr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Buffered results as plain queues; busy registers as a bit array.
    int       m_dest_q[$];
    int       m_data_q[$];
    bit       m_busy[NR];
    int       m_starve;
    bit       m_stall;
    bit       m_err;

    task automatic model_reset();
        m_dest_q.delete();
        m_data_q.delete();
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        m_starve = 0;
        m_stall  = 1'b0;
        m_err    = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rw, input logic m2r, input logic [AW-1:0] wd,
                        input logic [DW-1:0] mrd, input logic [DW-1:0] alu,
                        input logic iss, input logic [AW-1:0] isd,
                        input logic mv, input logic [AW-1:0] md, input logic [DW-1:0] mdat,
                        output logic accepted);
        logic          ready;
        logic          we;
        logic [NR-1:0] bvec;
        bit            popped;
        int            pdest;
        int            held;
        @(posedge clk);
        #1;
        RegWriteW = rw; MemToRegW = m2r; destAddW = wd;
        MemReadDataW = mrd; alu_resultW = alu;
        mc_issue = iss; mc_issue_dest = isd;
        mc_valid = mv; mc_dest = md; mc_data = mdat;

        held  = m_dest_q.size();
        ready = (held < DEPTH);
        we    = rw || (held > 0);
        for (int i = 0; i < NR; i++) bvec[i] = m_busy[i];
        exp_st_q.push_back({we, ready, m_stall, m_err, bvec});
        if (rw) exp_wr_q.push_back({wd, (m2r ? mrd : alu)});
        else if (held > 0) exp_wr_q.push_back({AW'(m_dest_q[0]), DW'(m_data_q[0])});

        // state at the closing edge
        popped = !rw && (held > 0);
        pdest  = popped ? m_dest_q[0] : 0;
        if (iss && m_busy[isd] && !(popped && pdest == int'(isd))) m_err = 1'b1;
        if (popped && !m_busy[pdest]) m_err = 1'b1;
        if (popped) m_busy[pdest] = 1'b0;
        if (iss) m_busy[isd] = 1'b1;
        if (popped) m_stall = 1'b0;
        else if (m_starve == LIMIT) m_stall = 1'b1;
        if (popped || held == 0) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        if (popped) begin
            void'(m_dest_q.pop_front());
            void'(m_data_q.pop_front());
        end
        accepted = mv && ready;
        if (accepted) begin
            m_dest_q.push_back(int'(md));
            m_data_q.push_back(int'(mdat));
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [19:0]      s;
        logic [AW+DW-1:0] w;
        if (reset && exp_st_q.size() > 0) begin
            s = exp_st_q.pop_front();
            check("rf_we", 32'(rf_we), 32'(s[19]));
            check("mc_ready", 32'(mc_ready), 32'(s[18]));
            check("stall_req", 32'(stall_req), 32'(s[17]));
            check("scoreboard_err", 32'(scoreboard_err), 32'(s[16]));
            check("busy_mask", 32'(busy_mask), 32'(s[15:0]));
            if (rf_we) begin
                if (exp_wr_q.size() == 0) begin
                    check("rf_write_unexpected", 32'(rf_waddr), 32'hFFFF_FFFF);
                end else begin
                    w = exp_wr_q.pop_front();
                    check("rf_waddr", 32'(rf_waddr), 32'(w[AW+DW-1:DW]));
                    check("rf_wdata", 32'(rf_wdata), 32'(w[DW-1:0]));
                end
            end
        end
    end

    // Asserts reset between a monitor sample and the next edge, checks the
    // immediate (asynchronous) effect, then releases it.
    task automatic do_reset();
        @(negedge clk);
        #1;
        check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
        exp_wr_q.delete();
        exp_st_q.delete();
        reset = 1'b0;
        RegWriteW = 1'b1; destAddW = 4'd6; alu_resultW = 16'h5555; MemToRegW = 1'b0;
        mc_issue = 1'b0; mc_valid = 1'b0;
        #1;
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_busy_mask", 32'(busy_mask), 32'd0);
        check("rst_stall_req", 32'(stall_req), 32'd0);
        check("rst_scoreboard_err", 32'(scoreboard_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        RegWriteW = 1'b0;
        reset = 1'b1;
        #1;
        check("rel_mc_ready", 32'(mc_ready), 32'd1);
        check("rel_rf_we", 32'(rf_we), 32'd0);
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        int   guard;
        int   pend_q[$];
        logic cur_v;
        logic [AW-1:0] cur_d;
        logic [DW-1:0] cur_data;

        reset = 1'b0;
        RegWriteW = 0; MemToRegW = 0; destAddW = 0; MemReadDataW = 0; alu_resultW = 0;
        mc_issue = 0; mc_issue_dest = 0; mc_valid = 0; mc_dest = 0; mc_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // W-stage path, both data selects
        step(1, 0, 3, 16'hBEEF, 16'h1234, 0, 0, 0, 0, 0, acc);
        step(1, 1, 3, 16'hBEEF, 16'h1234, 0, 0, 0, 0, 0, acc);

        // single multicycle op to r5
        step(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, acc);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 16'h00AA, acc);
        check("mc5_accepted", 32'(acc), 32'd1);
        idle(3);

        // fill while the W stage owns the port, hold the third, starve
        step(1, 0, 1, 0, 16'h0101, 1, 8, 0, 0, 0, acc);
        step(1, 0, 2, 0, 16'h0202, 1, 9, 0, 0, 0, acc);
        step(1, 0, 3, 0, 16'h0303, 1, 10, 1, 8, 16'h8888, acc);
        step(1, 0, 4, 0, 16'h0404, 0, 0, 1, 9, 16'h9999, acc);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, AW'(i), 16'hF000, DW'(i * 3), 0, 0, 1, 10, 16'hAAAA, acc);
            check("held_not_pushed", 32'(acc), 32'd0);
        end
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 10) begin
            step(0, 0, 0, 0, 0, 0, 0, 1, 10, 16'hAAAA, acc);
            guard++;
        end
        check("held_eventually_accepted", 32'(acc), 32'd1);
        idle(4);

        // same-cycle pop of r7 and re-issue to r7
        step(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 16'h0777, acc);
        step(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, acc);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 7, 16'h7007, acc);
        idle(3);

        // double issue to r2 -> sticky error
        step(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, acc);
        idle(4);
        do_reset();

        // randomized traffic with a well-behaved multicycle source
        cur_v = 1'b0; cur_d = '0; cur_data = '0;
        for (int n = 0; n < 400; n++) begin
            logic          rw, m2r, iss;
            logic [AW-1:0] wd, isd;
            logic [DW-1:0] mrd, alu;
            rw  = ($urandom_range(0, 99) < 55);
            m2r = $urandom_range(0, 1);
            wd  = AW'($urandom_range(0, NR - 1));
            mrd = DW'($urandom);
            alu = DW'($urandom);
            iss = 1'b0;
            isd = AW'($urandom_range(0, NR - 1));
            if ($urandom_range(0, 2) == 0 && !m_busy[isd]) iss = 1'b1;
            if (!cur_v && pend_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                cur_v    = 1'b1;
                cur_d    = AW'(pend_q.pop_front());
                cur_data = DW'($urandom);
            end
            step(rw, m2r, wd, mrd, alu, iss, isd, cur_v, cur_d, cur_data, acc);
            if (acc) cur_v = 1'b0;
            if (iss) pend_q.push_back(int'(isd));
        end
        // let the source and FIFO drain with the port free
        guard = 0;
        while ((cur_v || pend_q.size() > 0 || m_dest_q.size() > 0) && guard < 100) begin
            if (!cur_v && pend_q.size() > 0) begin
                cur_v    = 1'b1;
                cur_d    = AW'(pend_q.pop_front());
                cur_data = DW'($urandom);
            end
            step(0, 0, 0, 0, 0, 0, 0, cur_v, cur_d, cur_data, acc);
            if (acc) cur_v = 1'b0;
            guard++;
        end
        check("random_drain", 32'(m_dest_q.size() + pend_q.size()), 32'd0);
        idle(2);
        check("random_no_err", 32'(scoreboard_err), 32'd0);

        // reset while full and stalled, then confirm no stale writes
        step(1, 0, 1, 0, 16'h1111, 1, 11, 0, 0, 0, acc);
        step(1, 0, 1, 0, 16'h1111, 1, 12, 1, 11, 16'hB0B0, acc);
        step(1, 0, 1, 0, 16'h1111, 0, 0, 1, 12, 16'hC0C0, acc);
        for (int i = 0; i < 7; i++) step(1, 0, 2, 0, 16'h2222, 0, 0, 0, 0, 0, acc);
        check("pre_reset_stall", 32'(m_stall), 32'd1);
        do_reset();
        idle(5);
        @(negedge clk);
        #1;
        check("final_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
